// File: rtl/spwm_carrier_sequencer.sv
// Triangular SPWM carrier sequencer: prescaled up-ramp 0..TOP then down-ramp
// TOP..0, repeated until a stop completes a period or an abort cuts it short.
module spwm_carrier_sequencer #(
  parameter int WIDTH = 15,
  parameter int TOP   = 15358,
  parameter int PRESC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  output logic             busy,
  output logic             en_up,
  output logic             en_dn,
  output logic [WIDTH-1:0] carrier,
  output logic             step_tick,
  output logic             period_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam int               PW       = (PRESC < 1) ? 1 : $clog2(PRESC + 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESC);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [WIDTH-1:0] TOP_M1   = WIDTH'(TOP - 1);
  localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);

  state_t        state;
  logic [PW-1:0] pre_cnt;
  logic          stop_pending;
  logic          step_edge;

  assign step_edge = (pre_cnt == PRE_LAST);

  // Enables are decoded straight from the registered state.
  assign busy  = (state != IDLE);
  assign en_up = (state == UP);
  assign en_dn = (state == DOWN);

  // Phase FSM, prescaler, carrier count and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pre_cnt      <= '0;
      carrier      <= '0;
      stop_pending <= 1'b0;
      step_tick    <= 1'b0;
      period_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pre_cnt      <= '0;
          carrier      <= '0;
          stop_pending <= 1'b0;
          step_tick    <= 1'b0;
          period_done  <= 1'b0;
          if (start && !abort) begin
            state <= UP;
          end else begin
            state <= IDLE;
          end
        end

        UP, DOWN: begin
          if (abort) begin
            state        <= IDLE;
            pre_cnt      <= '0;
            carrier      <= '0;
            stop_pending <= 1'b0;
            step_tick    <= 1'b0;
            period_done  <= 1'b0;
          end else if (!step_edge) begin
            pre_cnt      <= pre_cnt + PRE_ONE;
            stop_pending <= stop_pending | stop;
            step_tick    <= 1'b0;
            period_done  <= 1'b0;
          end else begin
            pre_cnt   <= '0;
            step_tick <= 1'b1;
            if (state == UP) begin
              carrier      <= carrier + C_ONE;
              period_done  <= 1'b0;
              stop_pending <= stop_pending | stop;
              if (carrier == TOP_M1) begin
                state <= DOWN;
              end else begin
                state <= UP;
              end
            end else begin
              carrier <= carrier - C_ONE;
              if (carrier == C_ONE) begin
                // Period boundary: a pending or same-cycle stop ends the run here.
                period_done  <= 1'b1;
                stop_pending <= 1'b0;
                if (stop_pending || stop) begin
                  state <= IDLE;
                end else begin
                  state <= UP;
                end
              end else begin
                period_done  <= 1'b0;
                stop_pending <= stop_pending | stop;
                state        <= DOWN;
              end
            end
          end
        end

        default: begin
          state        <= IDLE;
          pre_cnt      <= '0;
          carrier      <= '0;
          stop_pending <= 1'b0;
          step_tick    <= 1'b0;
          period_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spwm_carrier_sequencer.sv
// Scoreboard bench for spwm_carrier_sequencer with TOP=4 at PRESC=0 and PRESC=2.
module tb_spwm_carrier_sequencer;

  typedef struct packed {
    logic [14:0] carrier;
    logic        busy;
    logic        en_up;
    logic        en_dn;
    logic        step_tick;
    logic        period_done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, stop_a = 1'b0, abort_a = 1'b0;
  logic start_b = 1'b0, stop_b = 1'b0, abort_b = 1'b0;
  logic busy_a, en_up_a, en_dn_a, tick_a, done_a;
  logic busy_b, en_up_b, en_dn_b, tick_b, done_b;
  logic [14:0] car_a, car_b;

  int total = 0;
  int bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  spwm_carrier_sequencer #(.WIDTH(15), .TOP(4), .PRESC(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .abort(abort_a),
    .busy(busy_a), .en_up(en_up_a), .en_dn(en_dn_a), .carrier(car_a),
    .step_tick(tick_a), .period_done(done_a)
  );

  spwm_carrier_sequencer #(.WIDTH(15), .TOP(4), .PRESC(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .abort(abort_b),
    .busy(busy_b), .en_up(en_up_b), .en_dn(en_dn_b), .carrier(car_b),
    .step_tick(tick_b), .period_done(done_b)
  );

  // Closed-form triangle for TOP=4: t clocks after the start edge.
  function automatic exp_t tri_exp(int t, int p);
    exp_t e;
    int s, ph;
    s  = t / (p + 1);
    ph = s % 8;
    e.carrier     = 15'((ph <= 4) ? ph : 8 - ph);
    e.busy        = 1'b1;
    e.en_up       = (ph < 4);
    e.en_dn       = (ph >= 4);
    e.step_tick   = (t > 0) && ((t % (p + 1)) == 0);
    e.period_done = e.step_tick && (ph == 0);
    return e;
  endfunction

  function automatic exp_t obs_a();
    return {car_a, busy_a, en_up_a, en_dn_a, tick_a, done_a};
  endfunction

  function automatic exp_t obs_b();
    return {car_b, busy_b, en_up_b, en_dn_b, tick_b, done_b};
  endfunction

  task automatic test_reset();
    exp_t got, e;
    @(negedge clk);
    q.push_back('0);
    got = obs_a(); e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_a got=%h exp=%h", got, e); end
    q.push_back('0);
    got = obs_b(); e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_b got=%h exp=%h", got, e); end
    rst_n = 1'b1;
  endtask

  task automatic abort_a_idle(string name);
    exp_t got, e;
    abort_a = 1'b1;
    q.push_back('0);
    @(posedge clk); @(negedge clk);
    abort_a = 1'b0;
    got = obs_a(); e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL %s got=%h exp=%h", name, got, e); end
  endtask

  task automatic test_basic();
    exp_t got, e;
    start_a = 1'b1;
    for (int t = 0; t < 20; t++) begin
      q.push_back(tri_exp(t, 0));
      @(posedge clk); @(negedge clk);
      start_a = 1'b0;
      got = obs_a(); e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL basic t=%0d got=%h exp=%h", t, got, e); end
    end
    abort_a_idle("basic_abort");
  endtask

  task automatic test_presc();
    exp_t got, e;
    start_b = 1'b1;
    for (int t = 0; t < 30; t++) begin
      q.push_back(tri_exp(t, 2));
      @(posedge clk); @(negedge clk);
      start_b = 1'b0;
      got = obs_b(); e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL presc t=%0d got=%h exp=%h", t, got, e); end
    end
    abort_b = 1'b1;
    q.push_back('0);
    @(posedge clk); @(negedge clk);
    abort_b = 1'b0;
    got = obs_b(); e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL presc_abort got=%h exp=%h", got, e); end
  endtask

  task automatic test_stop();
    exp_t got, e;
    start_a = 1'b1;
    for (int t = 0; t < 12; t++) begin
      stop_a = (t == 3);
      if (t < 8) e = tri_exp(t, 0);
      else if (t == 8) e = {15'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      else e = '0;
      q.push_back(e);
      @(posedge clk); @(negedge clk);
      start_a = 1'b0; stop_a = 1'b0;
      got = obs_a(); e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL stop t=%0d got=%h exp=%h", t, got, e); end
    end
  endtask

  task automatic test_abort();
    exp_t got, e;
    start_a = 1'b1;
    for (int t = 0; t < 6; t++) begin
      q.push_back(tri_exp(t, 0));
      @(posedge clk); @(negedge clk);
      start_a = 1'b0;
      got = obs_a(); e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL abort_run t=%0d got=%h exp=%h", t, got, e); end
    end
    abort_a_idle("abort_in_down");
    q.push_back('0);
    @(posedge clk); @(negedge clk);
    got = obs_a(); e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL abort_hold got=%h exp=%h", got, e); end
    start_a = 1'b1;
    for (int t = 0; t < 5; t++) begin
      q.push_back(tri_exp(t, 0));
      @(posedge clk); @(negedge clk);
      start_a = 1'b0;
      got = obs_a(); e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL abort_restart t=%0d got=%h exp=%h", t, got, e); end
    end
    abort_a_idle("abort_restart_end");
  endtask

  task automatic test_start_abort();
    exp_t got, e;
    start_a = 1'b1; abort_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      q.push_back('0);
      @(posedge clk); @(negedge clk);
      got = obs_a(); e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL start_abort i=%0d got=%h exp=%h", i, got, e); end
    end
    start_a = 1'b0; abort_a = 1'b0;
    for (int t = 0; t < 10; t++) begin
      start_a = (t == 0) || (t >= 3 && t <= 5);
      q.push_back(tri_exp(t, 0));
      @(posedge clk); @(negedge clk);
      got = obs_a(); e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL start_busy t=%0d got=%h exp=%h", t, got, e); end
    end
    start_a = 1'b0;
    abort_a_idle("start_busy_end");
  endtask

  task automatic test_back_to_back();
    exp_t got, e;
    start_a = 1'b1;
    for (int t = 0; t < 13; t++) begin
      stop_a = (t == 1);
      if (t < 8) e = tri_exp(t, 0);
      else if (t == 8) e = {15'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      else e = tri_exp(t - 9, 0);
      q.push_back(e);
      @(posedge clk); @(negedge clk);
      stop_a = 1'b0;
      got = obs_a(); e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL back_to_back t=%0d got=%h exp=%h", t, got, e); end
    end
    start_a = 1'b0;
    abort_a_idle("back_to_back_end");
  endtask

  task automatic test_reset_mid();
    exp_t got, e;
    start_a = 1'b1;
    for (int t = 0; t < 6; t++) begin
      q.push_back(tri_exp(t, 0));
      @(posedge clk); @(negedge clk);
      start_a = 1'b0;
      got = obs_a(); e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL rst_run t=%0d got=%h exp=%h", t, got, e); end
    end
    #2 rst_n = 1'b0;
    q.push_back('0);
    #1;
    got = obs_a(); e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL rst_async got=%h exp=%h", got, e); end
    for (int i = 0; i < 2; i++) begin
      q.push_back('0);
      @(negedge clk);
      got = obs_a(); e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL rst_hold i=%0d got=%h exp=%h", i, got, e); end
    end
    rst_n = 1'b1; start_a = 1'b1;
    for (int t = 0; t < 4; t++) begin
      q.push_back(tri_exp(t, 0));
      @(posedge clk); @(negedge clk);
      start_a = 1'b0;
      got = obs_a(); e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL rst_restart t=%0d got=%h exp=%h", t, got, e); end
    end
    abort_a_idle("rst_restart_end");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_presc();
    test_stop();
    test_abort();
    test_start_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spwm_carrier_sequencer.md
# spwm_carrier_sequencer

Controller that sequences the SPWM triangular carrier: a prescaled up-ramp 0→TOP followed by a down-ramp TOP→0, repeated until stopped. It owns the step prescaler, the up/down phase FSM and the carrier count, and drives the enable strobes for the downstream ramp and compare logic. It sits between the start/stop control and the SPWM comparator datapath.

## Interface
- WIDTH, 15: carrier width in bits.
- TOP, 15358: carrier peak value; legal range 2 ≤ TOP ≤ 2^WIDTH−1.
- PRESC, 2: a step occurs every PRESC+1 clocks; PRESC=0 steps every clock.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock, asynchronous assertion, active-low.
- start  in  1  level-sampled; in IDLE begins a carrier run.
- stop  in  1  one-cycle request; finish the current period, then return to IDLE.
- abort  in  1  immediate return to IDLE.
- busy  out  1  high in UP or DOWN.
- en_up  out  1  high while state is UP.
- en_dn  out  1  high while state is DOWN.
- carrier  out  WIDTH  current carrier value.
- step_tick  out  1  one-cycle pulse in the cycle a new carrier value first appears.
- period_done  out  1  one-cycle pulse when the carrier returns to 0 at the end of DOWN.

## Operation
- States: IDLE, UP, DOWN. All outputs are registered or decoded from registered state.
- Reset: state=IDLE; carrier=0; pre_cnt=0; stop_pending=0; busy, en_up, en_dn, step_tick and period_done all 0.
- Prescaler: pre_cnt counts 0..PRESC in UP and DOWN. A step edge is any edge where pre_cnt==PRESC; pre_cnt then returns to 0. pre_cnt is held at 0 in IDLE. Its width is max(1, clog2(PRESC+1)).
- IDLE: when start=1 and abort=0, go to UP with carrier=0 and pre_cnt=0.
- UP, on a step edge: carrier+1. When carrier==TOP−1, load carrier=TOP and go to DOWN.
- DOWN, on a step edge: carrier−1. When carrier==1, load carrier=0 and pulse period_done. Then go to IDLE if stop_pending or stop is set that cycle; otherwise go to UP.
- stop in UP or DOWN sets stop_pending. stop in IDLE is ignored. stop_pending clears on IDLE entry.
- abort in any state: on the next edge go to IDLE with carrier=0 and pre_cnt=0; clear stop_pending; no period_done.
- Simultaneous events: abort beats start and stop. start while busy is ignored. start held high across a stop completion restarts on the following cycle, because IDLE is occupied for one cycle minimum.
- Arithmetic is unsigned, WIDTH bits. The carrier never wraps and stays within 0..TOP by construction.
- The carrier sequence per period is 0,1,…,TOP,TOP−1,…,1,0, which is 2·TOP steps.

## Timing
- Start sampled at edge E0: busy, en_up=1 and carrier=0 from E0 onward. The first step is at edge E0+PRESC+1, carrier=1.
- Step spacing is PRESC+1 clocks. Carrier period is 2·TOP·(PRESC+1) clocks.
- step_tick is high for exactly the one cycle following each step edge.
- period_done coincides with step_tick in the cycle carrier shows 0 at the end of DOWN.
- en_up/en_dn switch on the same edge that loads TOP or 0.
- On the return to IDLE after stop, busy drops on the same edge as the final carrier=0.
- Reset mid-run forces the reset values immediately, asynchronously. Release is sampled on the next rising edge.

## Test plan
- TOP=4, PRESC=0, start pulse: carrier 0,1,2,3,4,3,2,1,0,1… one value per clock. en_up is high while carrier goes 0→4; en_dn is high from 4 back to 0. period_done pulses every 8 clocks.
- TOP=4, PRESC=2: each carrier value is held 3 clocks. step_tick fires every 3rd cycle. The period is 24 clocks.
- Stop pulsed mid-UP (TOP=4, PRESC=0): the run completes the down-ramp to 0. period_done pulses once. busy=0 on the next cycle and carrier=0 is held.
- Abort while carrier=3 in DOWN: next cycle state=IDLE, carrier=0, busy=0, no period_done. A later start restarts from 0.
- start and abort asserted together in IDLE: stays IDLE, all outputs 0. start while busy leaves the sequence unchanged.
- rst_n asserted low mid-DOWN for 2 cycles: all outputs 0 immediately. After release with start=1, the run restarts and the first step appears PRESC+1 clocks later.
